simple_dma_controller: RTL and testbench
========================================

Name: simple_dma_controller

Overview:
- Responder end of the device-side DMA handshake. It serves one requesting peripheral (dma_rqst, dma_rd_wr, start address, word count) and moves 16-bit words between system memory and that peripheral.
- Sits between the DMA-capable peripheral and a word-wide memory port.
- Reads from memory are delivered to the device on dev_in, qualified by dma_ack.
- Writes take dev_out and store it to memory.
- Completion is signalled with a one-cycle dma_end_flag.

Parameters:
- ADDR_STEP, 2, byte increment between consecutive word addresses.

Ports:
- clk  input  1  system clock
- reset  input  1  reset; asynchronous, active-high
- dma_rqst  input  1  transfer request from device (level)
- dma_rd_wr  input  1  1: memory read to device, 0: device write to memory
- dma_start_address  input  16  first byte address (bit 0 ignored, forced 0)
- dma_num_words  input  16  number of words to transfer
- dev_ack  input  1  device ready for next word (high = ready)
- dev_out  input  16  write data from device
- dev_in  output  16  read data to device
- dma_ack  output  1  one-cycle word strobe to device
- dma_end_flag  output  1  one-cycle transfer-complete pulse
- busy  output  1  high in every state except IDLE
- mem_addr  output  16  memory byte address
- mem_en  output  1  memory access request
- mem_we  output  2  byte write enables (2'b11 on write, 2'b00 on read)
- mem_din  output  16  memory write data
- mem_dout  input  16  memory read data, valid the cycle after an accepted read
- mem_ready  input  1  memory accepts access this cycle when mem_en=1

Behaviour:
Reset values:
- All registered outputs clear to 0: dev_in, dma_ack, dma_end_flag, busy.
- State is IDLE.
- Counters clear to 0.

States:
- IDLE:
  - On dma_rqst=1, latch cur_addr={dma_start_address[15:1],1'b0}, remain=dma_num_words, dir=dma_rd_wr.
  - If remain==0 go END, else go MEM_REQ.
  - Inputs are not re-sampled until the next IDLE.
- MEM_REQ:
  - Combinational outputs: mem_en=dma_rqst, mem_addr=cur_addr, mem_we=dir?2'b00:2'b11, mem_din=dev_out.
  - If dma_rqst=0, go IDLE (abort: no access, no end flag).
  - Else on mem_ready: read goes MEM_DATA, write goes ACK.
  - Else stay (wait states unbounded).
- MEM_DATA: register dev_in<=mem_dout; go ACK.
- ACK:
  - dma_ack=1 for exactly this cycle, with dev_in stable.
  - cur_addr+=ADDR_STEP (16-bit wrap, 16'hFFFE -> 16'h0000); remain-=1.
  - Next state: if remain==1 (last word) go END; elif dma_rqst=0 go IDLE; else go GUARD.
- GUARD: one cycle, dev_ack ignored (device flag settles); go WAIT_DEV.
- WAIT_DEV:
  - If dma_rqst=0, go IDLE.
  - Elif dev_ack=1, go MEM_REQ; else stay.
- END: dma_end_flag=1 for exactly this cycle; go HOLD.
- HOLD: stay while dma_rqst=1; go IDLE when dma_rqst=0. This prevents a restart on a stale request.

Rules:
- Latency, read: MEM_REQ accept -> MEM_DATA -> dma_ack. dma_ack is 2 cycles after the accepted MEM_REQ cycle.
- Latency, write: dma_ack is the cycle after the accepted MEM_REQ cycle.
- Minimum word period with dev_ack held high: 5 cycles for reads, 4 cycles for writes.
- dev_in holds its last read value between transfers and across writes.
- Aborts never interrupt an accepted memory access.
- dma_end_flag only on full completion; never on abort.
- Reset mid-transfer returns to IDLE immediately; an in-flight memory access is dropped.
- dma_num_words=16'hFFFF is legal; the address wraps.

Test Plan:
- Read 3 words from 16'h0200 (mem holds 16'hA001/A002/A003), dev_ack=1, mem_ready=1 -> mem_addr 0200/0202/0204; dma_ack pulses with dev_in=A001/A002/A003, 5 cycles apart; single dma_end_flag after the third ack; busy until dma_rqst drops.
- Write 2 words to 16'h0300, dev_out=16'hF00D -> mem_we=2'b11, mem_din=F00D at 0300 then 0302; 2 dma_ack; 1 dma_end_flag.
- dma_num_words=0 -> no mem_en; dma_end_flag 1 cycle after request; HOLD until dma_rqst=0.
- Read with dev_ack forced low after the first ack, released after 10 cycles -> second mem_en no earlier than the cycle after dev_ack rises.
- mem_ready low for 4 cycles -> mem_en and mem_addr held stable; ack timing shifted by 4 cycles.
- Start 16'hFFFE, 2 words -> second address 16'h0000. Separately, dma_rqst dropped in WAIT_DEV -> IDLE, no end flag, busy=0.

Source files
------------

// File: rtl/simple_dma_controller_if.sv
// ============================================================================
// Module      : simple_dma_controller_if
// Description : Bundles the device-side DMA handshake and the word-wide memory
//               port of simple_dma_controller.
//               slave  - the DMA controller (responder) side
//               master - the environment: requesting peripheral plus memory
// Ports       : dma_rqst, dma_rd_wr, dma_start_address, dma_num_words,
//               dev_ack, dev_out                       (device -> controller)
//               dev_in, dma_ack, dma_end_flag, busy     (controller -> device)
//               mem_addr, mem_en, mem_we, mem_din       (controller -> memory)
//               mem_dout, mem_ready                     (memory -> controller)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface simple_dma_controller_if;
  logic        dma_rqst;
  logic        dma_rd_wr;
  logic [15:0] dma_start_address;
  logic [15:0] dma_num_words;
  logic        dev_ack;
  logic [15:0] dev_out;
  logic [15:0] dev_in;
  logic        dma_ack;
  logic        dma_end_flag;
  logic        busy;
  logic [15:0] mem_addr;
  logic        mem_en;
  logic [1:0]  mem_we;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;
  logic        mem_ready;

  modport slave (
    input  dma_rqst, dma_rd_wr, dma_start_address, dma_num_words,
    input  dev_ack, dev_out, mem_dout, mem_ready,
    output dev_in, dma_ack, dma_end_flag, busy,
    output mem_addr, mem_en, mem_we, mem_din
  );

  modport master (
    output dma_rqst, dma_rd_wr, dma_start_address, dma_num_words,
    output dev_ack, dev_out, mem_dout, mem_ready,
    input  dev_in, dma_ack, dma_end_flag, busy,
    input  mem_addr, mem_en, mem_we, mem_din
  );
endinterface

`default_nettype wire

// File: rtl/simple_dma_controller.sv
// ============================================================================
// Module      : simple_dma_controller
// Description : Single-channel DMA responder. Serves one requesting peripheral
//               and moves 16-bit words between a word-wide memory port and the
//               device. Reads deliver memory data on dev_in with a one-cycle
//               dma_ack strobe; writes store dev_out to memory. Completion is
//               reported with a one-cycle dma_end_flag.
// Parameters  : ADDR_STEP - byte increment between consecutive word addresses
// Ports       : clk   - system clock
//               reset - asynchronous, active-high reset
//               bus   - simple_dma_controller_if.slave (device + memory side)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module simple_dma_controller #(
  parameter int unsigned ADDR_STEP = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  simple_dma_controller_if.slave      bus
);

  localparam logic [15:0] c_addr_step = 16'(ADDR_STEP);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MEM_REQ  = 3'd1,
    S_MEM_DATA = 3'd2,
    S_ACK      = 3'd3,
    S_GUARD    = 3'd4,
    S_WAIT_DEV = 3'd5,
    S_END      = 3'd6,
    S_HOLD     = 3'd7
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [15:0] r_cur_addr;
  logic [15:0] r_remain;
  logic        r_dir;       // 1: memory -> device, 0: device -> memory
  logic [15:0] r_dev_in;
  logic        r_dma_ack;
  logic        r_end_flag;
  logic        r_busy;

  logic        w_mem_en;
  logic [1:0]  w_mem_we;
  logic [15:0] w_mem_din;

  // --------------------------------------------------------------------------
  // Next-state and memory-port decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_next    = r_state;
    w_mem_en  = 1'b0;
    w_mem_we  = 2'b00;
    w_mem_din = 16'h0000;

    case (r_state)
      S_IDLE: begin
        if (bus.dma_rqst) begin
          w_next = (bus.dma_num_words == 16'h0000) ? S_END : S_MEM_REQ;
        end
      end

      S_MEM_REQ: begin
        // The request line gates the access itself so that an abort never
        // produces a memory cycle.
        w_mem_en  = bus.dma_rqst;
        w_mem_we  = r_dir ? 2'b00 : 2'b11;
        w_mem_din = bus.dev_out;
        if (!bus.dma_rqst) begin
          w_next = S_IDLE;
        end else if (bus.mem_ready) begin
          w_next = r_dir ? S_MEM_DATA : S_ACK;
        end
      end

      S_MEM_DATA: begin
        w_next = S_ACK;
      end

      S_ACK: begin
        // The last word always completes, even if the request has just dropped.
        if (r_remain == 16'd1) begin
          w_next = S_END;
        end else if (!bus.dma_rqst) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_GUARD;
        end
      end

      // dev_ack may still reflect the previous word here; give it a cycle.
      S_GUARD: begin
        w_next = S_WAIT_DEV;
      end

      S_WAIT_DEV: begin
        if (!bus.dma_rqst) begin
          w_next = S_IDLE;
        end else if (bus.dev_ack) begin
          w_next = S_MEM_REQ;
        end
      end

      S_END: begin
        w_next = S_HOLD;
      end

      // Wait for the request to drop so a stale level does not restart.
      S_HOLD: begin
        if (!bus.dma_rqst) begin
          w_next = S_IDLE;
        end
      end

      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State, counters and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cur_addr <= 16'h0000;
      r_remain   <= 16'h0000;
      r_dir      <= 1'b0;
      r_dev_in   <= 16'h0000;
      r_dma_ack  <= 1'b0;
      r_end_flag <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state <= w_next;

      // Strobes are registered from the next state so they are high exactly
      // while the controller sits in the matching state.
      r_dma_ack  <= (w_next == S_ACK);
      r_end_flag <= (w_next == S_END);
      r_busy     <= (w_next != S_IDLE);

      if (r_state == S_IDLE && bus.dma_rqst) begin
        r_cur_addr <= {bus.dma_start_address[15:1], 1'b0};
        r_remain   <= bus.dma_num_words;
        r_dir      <= bus.dma_rd_wr;
      end

      // Memory read data is valid the cycle after the accepted access.
      if (r_state == S_MEM_DATA) begin
        r_dev_in <= bus.mem_dout;
      end

      if (r_state == S_ACK) begin
        r_cur_addr <= r_cur_addr + c_addr_step;
        r_remain   <= r_remain - 16'd1;
      end
    end
  end

  assign bus.dev_in       = r_dev_in;
  assign bus.dma_ack      = r_dma_ack;
  assign bus.dma_end_flag = r_end_flag;
  assign bus.busy         = r_busy;
  assign bus.mem_addr     = r_cur_addr;
  assign bus.mem_en       = w_mem_en;
  assign bus.mem_we       = w_mem_we;
  assign bus.mem_din      = w_mem_din;

endmodule

`default_nettype wire

// File: tb/tb_simple_dma_controller.sv
// ============================================================================
// Module      : tb_simple_dma_controller
// Description : Self-checking bench for simple_dma_controller. A peripheral
//               and memory model drive the interface; every transfer is
//               recorded cycle by cycle and compared against a timeline
//               derived from the transfer rules and the stimulus history.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_simple_dma_controller;

  localparam int MAXC = 600;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  simple_dma_controller_if bus();

  simple_dma_controller #(.ADDR_STEP(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory contents (what the DUT sees) and the reference image.
  logic [15:0] mem     [0:32767];
  logic [15:0] ref_mem [0:32767];
  logic [15:0] last_rd;

  // Word memory: read data appears the cycle after the accepted access,
  // garbage otherwise so a wrongly timed capture is visible.
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_ready && bus.mem_we == 2'b00)
      bus.mem_dout <= mem[bus.mem_addr[15:1]];
    else
      bus.mem_dout <= 16'($urandom);
    if (bus.mem_en && bus.mem_ready && bus.mem_we == 2'b11)
      mem[bus.mem_addr[15:1]] <= bus.mem_din;
  end

  // Per-cycle history of one transfer.
  bit          a_rdy  [MAXC];
  bit          a_dack [MAXC];
  bit          a_men  [MAXC];
  bit          a_busy [MAXC];
  logic [15:0] a_maddr[MAXC];

  int          acc_cyc[$];
  logic [15:0] acc_addr[$];
  logic [15:0] acc_din[$];
  logic [1:0]  acc_we[$];
  int          ack_cyc[$];
  logic [15:0] ack_data[$];
  int          end_cyc[$];

  // rmode: 0 ready always, 1 random, 2 low for cycles 1..4
  // dmode: 0 dev_ack always, 1 random, 2 low for 10 cycles after first ack
  task automatic run_xfer(input bit rd, input logic [15:0] start, input logic [15:0] n,
                          input int rmode, input int dmode, input bit abort);
    logic [15:0] wdata[$];
    logic [15:0] ea;
    int c, drop_c, first_ack, ack_n, nn, c_last;
    int t, acc, ack, u, bad, exp_end, exp_men, obs_men;
    bit rq, rdy, dack;

    nn = int'(n);
    wdata.delete();
    for (int i = 0; i < nn; i++) wdata.push_back(16'($urandom));
    acc_cyc.delete(); acc_addr.delete(); acc_din.delete(); acc_we.delete();
    ack_cyc.delete(); ack_data.delete(); end_cyc.delete();
    c = 0; drop_c = -1; first_ack = -1; ack_n = 0; rq = 1'b1;

    while (1) begin
      @(posedge clk);
      #1;
      if (c == 0) begin
        bus.dma_rd_wr         = rd;
        bus.dma_start_address = start;
        bus.dma_num_words     = n;
      end else begin
        // Must be ignored once latched.
        bus.dma_rd_wr         = 1'($urandom);
        bus.dma_start_address = 16'($urandom);
        bus.dma_num_words     = 16'($urandom);
      end
      case (rmode)
        1:       rdy = ($urandom_range(2) != 0);
        2:       rdy = !(c >= 1 && c <= 4);
        default: rdy = 1'b1;
      endcase
      if (abort)           dack = (first_ack < 0);
      else if (dmode == 1) dack = 1'($urandom_range(1));
      else if (dmode == 2) dack = (first_ack < 0) || (c > first_ack + 10);
      else                 dack = 1'b1;
      if (abort && first_ack >= 0 && c == first_ack + 3) rq = 1'b0;
      if (!abort && end_cyc.size() > 0 && c == end_cyc[0] + 4) begin
        rq = 1'b0;
        drop_c = c;
      end
      bus.dev_out   = (ack_n < nn) ? wdata[ack_n] : 16'($urandom);
      bus.dma_rqst  = rq;
      bus.mem_ready = rdy;
      bus.dev_ack   = dack;
      #1;
      a_rdy[c]   = rdy;
      a_dack[c]  = dack;
      a_men[c]   = bus.mem_en;
      a_busy[c]  = bus.busy;
      a_maddr[c] = bus.mem_addr;
      if (bus.mem_en && rdy) begin
        acc_cyc.push_back(c);
        acc_addr.push_back(bus.mem_addr);
        acc_din.push_back(bus.mem_din);
        acc_we.push_back(bus.mem_we);
      end
      if (bus.dma_ack) begin
        ack_cyc.push_back(c);
        ack_data.push_back(bus.dev_in);
        if (first_ack < 0) first_ack = c;
        ack_n++;
      end
      if (bus.dma_end_flag) end_cyc.push_back(c);
      c++;
      if (!abort && drop_c >= 0 && c > drop_c + 2) break;
      if (abort && first_ack >= 0 && c > first_ack + 6) break;
      if (c >= MAXC) begin
        check("timeout", c, 0);
        bus.dma_rqst = 1'b0;
        return;
      end
    end
    c_last = c;
    check("busy_idle_at_req", a_busy[0], 0);

    if (abort) begin
      check("abort_acks", ack_cyc.size(), 1);
      check("abort_accesses", acc_cyc.size(), 1);
      check("abort_no_end", end_cyc.size(), 0);
      check("abort_busy_before", a_busy[first_ack + 3], 1);
      check("abort_busy_after", a_busy[first_ack + 4], 0);
      if (rd) last_rd = ref_mem[start[15:1]];
      else    ref_mem[start[15:1]] = wdata[0];
      return;
    end

    obs_men = 0;
    for (int i = 0; i < c_last; i++) obs_men += int'(a_men[i]);
    check("ack_count", ack_cyc.size(), nn);
    check("acc_count", acc_cyc.size(), nn);
    check("end_count", end_cyc.size(), 1);

    ea = {start[15:1], 1'b0};
    t = 1; exp_men = 0; exp_end = 1;
    for (int i = 0; i < nn; i++) begin
      acc = t;
      while (acc < c_last && !a_rdy[acc]) acc++;
      bad = 0;
      for (int k = t; k <= acc && k < c_last; k++)
        if (!a_men[k] || a_maddr[k] !== ea) bad++;
      check("req_hold", bad, 0);
      exp_men += acc - t + 1;
      ack = acc + (rd ? 2 : 1);
      if (i < acc_cyc.size()) begin
        check("acc_cycle", acc_cyc[i], acc);
        check("acc_addr", acc_addr[i], ea);
        check("acc_we", acc_we[i], rd ? 2'b00 : 2'b11);
        if (!rd) check("acc_din", acc_din[i], wdata[i]);
      end
      if (i < ack_cyc.size()) begin
        check("ack_cycle", ack_cyc[i], ack);
        if (rd) check("ack_data", ack_data[i], ref_mem[ea[15:1]]);
      end
      if (rd) last_rd = ref_mem[ea[15:1]];
      else    ref_mem[ea[15:1]] = wdata[i];
      ea = ea + 16'd2;
      if (i == nn - 1) exp_end = ack + 1;
      else begin
        u = ack + 2;
        while (u < c_last && !a_dack[u]) u++;
        t = u + 1;
      end
    end
    check("mem_en_cycles", obs_men, exp_men);
    if (end_cyc.size() > 0) begin
      check("end_cycle", end_cyc[0], exp_end);
      check("busy_in_hold", a_busy[end_cyc[0] + 3], 1);
    end
    if (drop_c >= 0) check("busy_after_drop", a_busy[drop_c + 1], 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.dma_rqst = 0; bus.dma_rd_wr = 0; bus.dma_start_address = 0;
    bus.dma_num_words = 0; bus.dev_ack = 0; bus.dev_out = 0; bus.mem_ready = 0;
    for (int i = 0; i < 32768; i++) begin
      mem[i]     = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    for (int i = 0; i < 3; i++) begin
      mem[16'h0100 + i]     = 16'hA001 + 16'(i);
      ref_mem[16'h0100 + i] = 16'hA001 + 16'(i);
    end
    last_rd = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_dma_ack", bus.dma_ack, 0);
    check("rst_end_flag", bus.dma_end_flag, 0);
    check("rst_dev_in", bus.dev_in, 0);
    check("rst_mem_en", bus.mem_en, 0);
    @(negedge clk);
    reset = 1'b0;

    run_xfer(1'b1, 16'h0200, 16'd3, 0, 0, 1'b0);   // A001/A002/A003
    check("devin_last_read", bus.dev_in, 16'hA003);
    run_xfer(1'b0, 16'h0300, 16'd2, 0, 0, 1'b0);
    check("devin_hold_write", bus.dev_in, last_rd);
    run_xfer(1'b1, 16'h0300, 16'd2, 1, 1, 1'b0);   // read back written words
    run_xfer(1'b1, 16'h1234, 16'd0, 0, 0, 1'b0);   // zero-length
    run_xfer(1'b1, 16'h0400, 16'd3, 0, 2, 1'b0);   // device holds off
    run_xfer(1'b0, 16'h0500, 16'd2, 2, 0, 1'b0);   // memory wait states
    run_xfer(1'b1, 16'hFFFF, 16'd2, 0, 0, 1'b0);   // bit 0 dropped, wrap
    run_xfer(1'b1, 16'h0600, 16'd4, 0, 0, 1'b1);   // abort in WAIT_DEV
    for (int k = 0; k < 6; k++)
      run_xfer(1'($urandom), 16'($urandom), 16'($urandom_range(6, 1)), 1, 1, 1'b0);

    // Asynchronous reset in the middle of a read.
    @(posedge clk); #1;
    bus.dma_rd_wr = 1'b1; bus.dma_start_address = 16'h0700;
    bus.dma_num_words = 16'd4; bus.dma_rqst = 1'b1;
    bus.mem_ready = 1'b1; bus.dev_ack = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_mem_en", bus.mem_en, 0);
    check("midrst_dev_in", bus.dev_in, 0);
    bus.dma_rqst = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    last_rd = 16'h0000;
    run_xfer(1'b1, 16'h0700, 16'd2, 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
